l3_frontend: RTL
================

# l3_frontend

Command front-end for the layer-3 core cluster. Takes the SPI byte stream, parses a 6-byte header plus word payload, and drives the shared `l3_*` command/write-data bus plus a one-hot core select. It returns core read data and the response byte as an outbound byte stream. It sits directly upstream of the key-management core and its siblings, and owns command sequencing, payload packing and the response timeout.

## Interface
Parameters:
- `NCORE`, default 4: number of selectable cores; core index 0 is the key-management core.
- `TMO`, default 65535: response-wait timeout, in clk cycles.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_byte`  in  8: inbound byte from the SPI slave.
- `rx_vld`  in  1: `rx_byte` valid.
- `rx_rdy`  out  1: byte accepted when `rx_vld & rx_rdy`.
- `tx_byte`  out  8: outbound byte to the SPI slave.
- `tx_vld`  out  1: `tx_byte` valid.
- `tx_rdy`  in  1: byte consumed when `tx_vld & tx_rdy`.
- `core_sel`  out  NCORE: one-hot select of the addressed core.
- `l3_en`  out  1: command strobe.
- `l3_op`  out  8: opcode.
- `l3_extend`  out  16: extend field.
- `l3_id`  out  4: session id.
- `l3_size`  out  16: payload length in 32-bit words.
- `l3_wd`  out  32: write data word.
- `l3_wd_vld`  out  1: write word valid.
- `core_wd_rdy`  in  1: selected core ready for the write word (muxed externally).
- `core_rd`  in  32: read data from the selected core.
- `core_rd_vld`  in  1: read word valid.
- `l3_rd_rdy`  out  1: read word accepted.
- `core_resp`  in  8: response code from the selected core.
- `core_resp_vld`  in  1: response valid.
- `resp_rdy`  out  1: response accepted.
- `busy`  out  1: high in any state other than IDLE.

## Operation
Header bytes, in order:
- B0: [7:4] core index, [3:0] `l3_id`.
- B1: `l3_op`.
- B2–B3: `l3_extend`, MSB first.
- B4–B5: `l3_size`, MSB first.

Payload: `l3_size` words, 4 bytes each, MSB first. The word is packed to `l3_wd[31:24]` first.

FSM states: IDLE, HDR, CMD, WDATA, WAIT, DRAIN, ERR.
- **IDLE:** `rx_rdy`=1. The first accepted byte loads B0 and moves to HDR with byte counter = 1.
- **HDR:** accepts B1–B5. On B5:
  - If core index ≥ NCORE, go to ERR.
  - Otherwise go to CMD.
- **CMD:** one cycle. `l3_en`=1, `core_sel` one-hot set. Go to WDATA if `l3_size`≠0, else WAIT.
- **WDATA:** `rx_rdy`=1 while the pack register is not full. After the 4th byte, `l3_wd_vld`=1 and `rx_rdy`=0 until `core_wd_rdy`. Word counter increments on each `l3_wd_vld & core_wd_rdy`. After the last word, go to WAIT.
- **WAIT:**
  - Timeout counter starts at 0 on WAIT entry and increments every cycle.
  - `l3_rd_rdy`=1 only when the tx serializer is empty. Each accepted `core_rd` word is loaded into the serializer, sent as 4 tx bytes MSB first, and resets the timeout counter.
  - `resp_rdy`=1 only when the serializer is empty and `core_rd_vld`=0; read words always precede the response.
  - An accepted response loads the serializer with `core_resp` as a single byte and goes to DRAIN.
  - Counter reaching TMO−1 loads 8'hE2 and goes to DRAIN.
- **ERR:** discards B6.. payload bytes (`rx_rdy`=1, `size`×4 bytes). Issues no `l3_en` and sets no `core_sel`. Then loads 8'hE1 and goes to DRAIN.
- **DRAIN:** when the last tx byte is consumed, clear `core_sel` and return to IDLE.

## Timing
- Reset value of every output: `rx_rdy`=0 in the reset cycle and 1 from the next cycle (IDLE). All other outputs 0, including `busy`, `core_sel`, `tx_vld`, `l3_en`, `l3_wd_vld`, `l3_rd_rdy`, `resp_rdy`, and all data buses.
- `rst` mid-operation: next cycle is IDLE. Partial header/payload and serializer contents are dropped, and no response byte is sent.
- `l3_op`, `l3_extend`, `l3_id` and `l3_size` are registered and stable from CMD until return to IDLE.
- `core_sel` is stable from CMD until DRAIN completes.
- Latency:
  - B5 accepted in cycle n gives `l3_en` in cycle n+1.
  - The 4th payload byte accepted in cycle m gives `l3_wd_vld` in cycle m+1.
  - `core_resp` accepted in cycle k gives `tx_vld` in cycle k+1.
- `l3_wd_vld` and `tx_vld` hold, with data stable, until their handshake completes; no retraction.
- `core_resp_vld` together with `core_rd_vld` in the same cycle: the read word is taken first and the response is deferred.
- Byte counter is 3 bits and word counter is 16 bits. `l3_size`=16'hFFFF is legal; there is no wrap before completion.
- `rx_rdy`=0 in CMD, WAIT and DRAIN.

## Test plan
- Header 0x05,0x10,0x00,0x02,0x00,0x00 with core_resp 0x01 after 3 cycles -> one `l3_en` pulse; `core_sel`=4'b0001, `l3_id`=5, `l3_op`=0x10, `l3_extend`=2, `l3_size`=0; tx emits 0x01 alone.
- Size 2, payload 11 22 33 44 AA BB CC DD, with `core_wd_rdy` low for 5 cycles on the first word -> `l3_wd`=0x11223344 held through the stall, then 0xAABBCCDD; exactly 2 write handshakes.
- Read command: core returns rd 0xDEADBEEF and 0x01020304, then resp 0x00, with `tx_rdy` toggling -> tx DE AD BE EF 01 02 03 04 00, in order, none lost.
- B0=0x52 with NCORE=4 and size 1 -> 4 payload bytes consumed, no `l3_en`, `core_sel` stays 0, tx 0xE1.
- TMO=16, no response -> tx 0xE2 exactly 16 cycles after WAIT entry; `core_sel` cleared after DRAIN.
- `rst` pulsed during WDATA word 1 -> all outputs 0 next cycle; a following clean command completes normally.

Source files
------------

// File: rtl/l3_frontend_if.sv
// SPI byte streams, shared l3 command/write-data bus and core return paths of the l3 front-end.
// master = the front-end itself, slave = SPI slave plus core cluster.
interface l3_frontend_if #(
  parameter int NCORE = 4
);
  logic [7:0]       rx_byte;
  logic             rx_vld;
  logic             rx_rdy;
  logic [7:0]       tx_byte;
  logic             tx_vld;
  logic             tx_rdy;
  logic [NCORE-1:0] core_sel;
  logic             l3_en;
  logic [7:0]       l3_op;
  logic [15:0]      l3_extend;
  logic [3:0]       l3_id;
  logic [15:0]      l3_size;
  logic [31:0]      l3_wd;
  logic             l3_wd_vld;
  logic             core_wd_rdy;
  logic [31:0]      core_rd;
  logic             core_rd_vld;
  logic             l3_rd_rdy;
  logic [7:0]       core_resp;
  logic             core_resp_vld;
  logic             resp_rdy;
  logic             busy;

  modport master (
    input  rx_byte, rx_vld, tx_rdy, core_wd_rdy, core_rd, core_rd_vld, core_resp, core_resp_vld,
    output rx_rdy, tx_byte, tx_vld, core_sel, l3_en, l3_op, l3_extend, l3_id, l3_size,
           l3_wd, l3_wd_vld, l3_rd_rdy, resp_rdy, busy
  );

  modport slave (
    output rx_byte, rx_vld, tx_rdy, core_wd_rdy, core_rd, core_rd_vld, core_resp, core_resp_vld,
    input  rx_rdy, tx_byte, tx_vld, core_sel, l3_en, l3_op, l3_extend, l3_id, l3_size,
           l3_wd, l3_wd_vld, l3_rd_rdy, resp_rdy, busy
  );
endinterface

// File: rtl/l3_frontend.sv
// Parses SPI header+payload into l3 commands/write words and serializes core read data and response bytes.
// l3_en one cycle after B5, l3_wd_vld one cycle after each 4th payload byte; rx/tx/wd/rd/resp all valid-ready.
module l3_frontend #(
  parameter int NCORE = 4,
  parameter int TMO   = 65535
) (
  input  logic          clk,
  input  logic          rst,
  l3_frontend_if.master bus
);

  typedef enum logic [2:0] {IDLE, HDR, CMD, WDATA, WAIT, DRAIN, ERR} state_t;
  state_t state, state_nxt;

  logic [2:0]       bcnt;
  logic [15:0]      wcnt;
  logic [3:0]       core_idx;
  logic [3:0]       id;
  logic [7:0]       op;
  logic [15:0]      ext;
  logic [15:0]      size;
  logic [31:0]      pack;
  logic [31:0]      ser;
  logic [2:0]       ser_cnt;
  logic [31:0]      tmo_cnt;
  logic [NCORE-1:0] sel;

  logic        rx_ok, wd_vld, rd_rdy, rsp_rdy, en;
  logic        ser_load;
  logic [31:0] ser_dat;
  logic [2:0]  ser_num;
  logic        rx_fire, wd_fire, rd_fire, rsp_fire, tx_fire;
  logic        ser_empty, bad_core, tmo_hit, last_word;

  assign rx_fire   = bus.rx_vld & rx_ok & ~rst;
  assign wd_fire   = wd_vld & bus.core_wd_rdy;
  assign rd_fire   = rd_rdy & bus.core_rd_vld;
  assign rsp_fire  = rsp_rdy & bus.core_resp_vld;
  assign ser_empty = (ser_cnt == 3'd0);
  assign tx_fire   = ~ser_empty & bus.tx_rdy;
  assign bad_core  = {28'd0, core_idx} >= 32'(NCORE);
  assign tmo_hit   = tmo_cnt >= 32'(TMO - 1);
  assign last_word = (wcnt == size - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ok     = 1'b0;
    en        = 1'b0;
    wd_vld    = 1'b0;
    rd_rdy    = 1'b0;
    rsp_rdy   = 1'b0;
    ser_load  = 1'b0;
    ser_dat   = '0;
    ser_num   = '0;
    case (state)
      IDLE: begin
        rx_ok = 1'b1;
        if (rx_fire) state_nxt = HDR;
      end
      HDR: begin
        rx_ok = 1'b1;
        if (rx_fire && bcnt == 3'd5) state_nxt = bad_core ? ERR : CMD;
      end
      CMD: begin
        en        = 1'b1;
        state_nxt = (size != 16'd0) ? WDATA : WAIT;
      end
      WDATA: begin
        rx_ok  = (bcnt != 3'd4);
        wd_vld = (bcnt == 3'd4);
        if (wd_fire && last_word) state_nxt = WAIT;
      end
      WAIT: begin
        rd_rdy  = ser_empty;
        rsp_rdy = ser_empty & ~bus.core_rd_vld;
        if (rd_fire) begin
          ser_load = 1'b1;
          ser_dat  = bus.core_rd;
          ser_num  = 3'd4;
        end else if (rsp_fire) begin
          ser_load  = 1'b1;
          ser_dat   = {bus.core_resp, 24'h0};
          ser_num   = 3'd1;
          state_nxt = DRAIN;
        // a saturated timeout waits for pending read bytes so they are never overwritten
        end else if (ser_empty && tmo_hit) begin
          ser_load  = 1'b1;
          ser_dat   = {8'hE2, 24'h0};
          ser_num   = 3'd1;
          state_nxt = DRAIN;
        end
      end
      ERR: begin
        rx_ok = (wcnt != size);
        if (wcnt == size) begin
          ser_load  = 1'b1;
          ser_dat   = {8'hE1, 24'h0};
          ser_num   = 3'd1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ser_empty || (ser_cnt == 3'd1 && tx_fire)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      wcnt     <= '0;
      core_idx <= '0;
      id       <= '0;
      op       <= '0;
      ext      <= '0;
      size     <= '0;
      pack     <= '0;
      ser      <= '0;
      ser_cnt  <= '0;
      tmo_cnt  <= '0;
      sel      <= '0;
    end else begin
      if (ser_load) begin
        ser     <= ser_dat;
        ser_cnt <= ser_num;
      end else if (tx_fire) begin
        ser     <= {ser[23:0], 8'h00};
        ser_cnt <= ser_cnt - 3'd1;
      end

      if (state != WAIT || rd_fire) tmo_cnt <= '0;
      else if (!tmo_hit)            tmo_cnt <= tmo_cnt + 32'd1;

      if (state == DRAIN && state_nxt == IDLE) sel <= '0;

      case (state)
        IDLE: if (rx_fire) begin
          core_idx <= bus.rx_byte[7:4];
          id       <= bus.rx_byte[3:0];
          bcnt     <= 3'd1;
        end
        HDR: if (rx_fire) begin
          case (bcnt)
            3'd1:    op         <= bus.rx_byte;
            3'd2:    ext[15:8]  <= bus.rx_byte;
            3'd3:    ext[7:0]   <= bus.rx_byte;
            3'd4:    size[15:8] <= bus.rx_byte;
            3'd5:    size[7:0]  <= bus.rx_byte;
            default: ;
          endcase
          bcnt <= (bcnt == 3'd5) ? 3'd0 : bcnt + 3'd1;
          wcnt <= '0;
          if (bcnt == 3'd5 && !bad_core) sel <= {{(NCORE-1){1'b0}}, 1'b1} << core_idx;
        end
        WDATA: begin
          if (rx_fire) begin
            pack <= {pack[23:0], bus.rx_byte};
            bcnt <= bcnt + 3'd1;
          end
          if (wd_fire) begin
            bcnt <= '0;
            wcnt <= wcnt + 16'd1;
          end
        end
        // bad core index: payload is counted off and dropped word by word
        ERR: if (rx_fire) begin
          if (bcnt == 3'd3) begin
            bcnt <= '0;
            wcnt <= wcnt + 16'd1;
          end else begin
            bcnt <= bcnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_rdy    = rx_ok & ~rst;
  assign bus.tx_byte   = ser[31:24];
  assign bus.tx_vld    = ~ser_empty;
  assign bus.core_sel  = sel;
  assign bus.l3_en     = en;
  assign bus.l3_op     = op;
  assign bus.l3_extend = ext;
  assign bus.l3_id     = id;
  assign bus.l3_size   = size;
  assign bus.l3_wd     = pack;
  assign bus.l3_wd_vld = wd_vld;
  assign bus.l3_rd_rdy = rd_rdy;
  assign bus.resp_rdy  = rsp_rdy;
  assign bus.busy      = (state != IDLE);

endmodule
